// File: rtl/jt51_timer_pkg.sv
// jt51_timer_pkg
// Shared constants for the JT51 timer front-end: register addresses,
// bit positions inside the timer control register (0x14) and the state
// encodings of the busy and CSM sequencers.
package jt51_timer_pkg;

  // Timer register addresses
  localparam logic [7:0] TMR_A_HI = 8'h10;
  localparam logic [7:0] TMR_A_LO = 8'h11;
  localparam logic [7:0] TMR_B    = 8'h12;
  localparam logic [7:0] TMR_CTRL = 8'h14;

  // Bit positions in the control register
  localparam int CSM  = 7;
  localparam int CLRB = 5;
  localparam int CLRA = 4;
  localparam int IRQB = 3;
  localparam int IRQA = 2;
  localparam int LDB  = 1;
  localparam int LDA  = 0;

  // Busy window sequencer states
  typedef logic [0:0] busy_state_t;
  localparam busy_state_t BUSY_IDLE = 1'b0;
  localparam busy_state_t BUSY_BUSY = 1'b1;

  // CSM key-on sequencer states
  typedef logic [0:0] csm_state_t;
  localparam csm_state_t CSM_IDLE  = 1'b0;
  localparam csm_state_t CSM_KEYON = 1'b1;

endpackage

// File: rtl/jt51_csm_seq.sv
// jt51_csm_seq
// Composite sine mode key-on sequencer. A timer A overflow seen on a cen
// tick while csm is set raises csm_kon for CSM_TICKS cen ticks. Further
// overflows during the key-on window restart the count, and clearing csm
// aborts the window.
//
// Ports:
//   rst        asynchronous active-high reset
//   clk        clock
//   cen        clock enable shared with the timers
//   csm        registered CSM mode bit
//   overflow_A timer A overflow
//   csm_kon    key-on request for all channels
module jt51_csm_seq
  import jt51_timer_pkg::*;
#(
  parameter int CSM_TICKS = 32
) (
  input  logic rst,
  input  logic clk,
  input  logic cen,
  input  logic csm,
  input  logic overflow_A,
  output logic csm_kon
);

  localparam logic [7:0] CSM_LOAD = 8'(CSM_TICKS);

  csm_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       trigger;

  // csm is the registered mode bit, so a control write landing on the same
  // edge as an overflow is still judged by the old mode value.
  assign trigger = csm & overflow_A & cen;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CSM_KEYON && !csm) begin
      state_d = CSM_IDLE;
      cnt_d   = 8'd0;
    end else if (trigger) begin
      // Entering or retriggering both reload the full sweep
      state_d = CSM_KEYON;
      cnt_d   = CSM_LOAD;
    end else if (state_q == CSM_KEYON && cen) begin
      if (cnt_q <= 8'd1) begin
        state_d = CSM_IDLE;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CSM_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign csm_kon = (state_q == CSM_KEYON);

endmodule

// File: rtl/jt51_timer_ctrl.sv
// jt51_timer_ctrl
// CPU-side register front-end for the two JT51 timers. Latches the
// register address, decodes data writes to 0x10/0x11/0x12/0x14, drives the
// timer load/clear/IRQ-enable controls, models the write-busy window and
// hosts the CSM key-on sequencer.
//
// Ports:
//   rst, clk, cen          reset, clock and shared clock enable
//   wr, a0, din            CPU write strobe, address/data select, data
//   overflow_A             timer A overflow
//   busy                   write-busy status
//   value_A, value_B       timer start values
//   load_A, load_B         timer run/load levels
//   clr_flag_A, clr_flag_B one-clk flag clear pulses
//   enable_irq_A/B         IRQ enables
//   csm, csm_kon           CSM mode bit and key-on request
module jt51_timer_ctrl
  import jt51_timer_pkg::*;
#(
  parameter int BUSY_TICKS = 64,
  parameter int CSM_TICKS  = 32
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       overflow_A,
  output logic       busy,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       csm,
  output logic       csm_kon
);

  localparam logic [7:0] BUSY_LOAD = 8'(BUSY_TICKS);

  logic [7:0]  addr_q, addr_d;
  logic [9:0]  value_a_q, value_a_d;
  logic [7:0]  value_b_q, value_b_d;
  logic        load_a_q, load_a_d, load_b_q, load_b_d;
  logic        irq_a_q, irq_a_d, irq_b_q, irq_b_d;
  logic        clr_a_q, clr_a_d, clr_b_q, clr_b_d;
  logic        csm_q, csm_d;
  busy_state_t busy_state_q, busy_state_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic        data_wr;

  // Data writes are only honoured outside the busy window; address writes
  // are always taken.
  assign data_wr = wr & a0 & (busy_state_q == BUSY_IDLE);

  // Address latch and register decode. Clear pulses default low so they
  // last exactly one clk regardless of cen.
  always_comb begin
    addr_d    = addr_q;
    value_a_d = value_a_q;
    value_b_d = value_b_q;
    load_a_d  = load_a_q;
    load_b_d  = load_b_q;
    irq_a_d   = irq_a_q;
    irq_b_d   = irq_b_q;
    csm_d     = csm_q;
    clr_a_d   = 1'b0;
    clr_b_d   = 1'b0;
    if (wr && !a0) addr_d = din;
    if (data_wr) begin
      case (addr_q)
        TMR_A_HI: value_a_d[9:2] = din;
        TMR_A_LO: value_a_d[1:0] = din[1:0];
        TMR_B:    value_b_d      = din;
        TMR_CTRL: begin
          csm_d    = din[CSM];
          clr_b_d  = din[CLRB];
          clr_a_d  = din[CLRA];
          irq_b_d  = din[IRQB];
          irq_a_d  = din[IRQA];
          load_b_d = din[LDB];
          load_a_d = din[LDA];
        end
        default: ;
      endcase
    end
  end

  // Busy window: any accepted data write, whatever its address, reloads the
  // tick counter; the final cen tick drops busy on the same edge.
  always_comb begin
    busy_state_d = busy_state_q;
    busy_cnt_d   = busy_cnt_q;
    if (data_wr) begin
      busy_state_d = BUSY_BUSY;
      busy_cnt_d   = BUSY_LOAD;
    end else if (busy_state_q == BUSY_BUSY && cen) begin
      if (busy_cnt_q <= 8'd1) begin
        busy_state_d = BUSY_IDLE;
        busy_cnt_d   = 8'd0;
      end else begin
        busy_cnt_d = busy_cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= 8'd0;
      value_a_q    <= 10'd0;
      value_b_q    <= 8'd0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      irq_a_q      <= 1'b0;
      irq_b_q      <= 1'b0;
      clr_a_q      <= 1'b0;
      clr_b_q      <= 1'b0;
      csm_q        <= 1'b0;
      busy_state_q <= BUSY_IDLE;
      busy_cnt_q   <= 8'd0;
    end else begin
      addr_q       <= addr_d;
      value_a_q    <= value_a_d;
      value_b_q    <= value_b_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      irq_a_q      <= irq_a_d;
      irq_b_q      <= irq_b_d;
      clr_a_q      <= clr_a_d;
      clr_b_q      <= clr_b_d;
      csm_q        <= csm_d;
      busy_state_q <= busy_state_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  jt51_csm_seq #(
    .CSM_TICKS (CSM_TICKS)
  ) u_csm_seq (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .csm        (csm_q),
    .overflow_A (overflow_A),
    .csm_kon    (csm_kon)
  );

  assign busy         = (busy_state_q == BUSY_BUSY);
  assign value_A      = value_a_q;
  assign value_B      = value_b_q;
  assign load_A       = load_a_q;
  assign load_B       = load_b_q;
  assign clr_flag_A   = clr_a_q;
  assign clr_flag_B   = clr_b_q;
  assign enable_irq_A = irq_a_q;
  assign enable_irq_B = irq_b_q;
  assign csm          = csm_q;

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// tb_jt51_timer_ctrl
// Directed bench for jt51_timer_ctrl with default parameters
// (BUSY_TICKS=64, CSM_TICKS=32). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_jt51_timer_ctrl;

  logic       rst, clk, cen, wr, a0, overflow_A;
  logic [7:0] din;
  logic       busy, load_A, load_B, clr_flag_A, clr_flag_B;
  logic       enable_irq_A, enable_irq_B, csm, csm_kon;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic [26:0] allOuts;

  int compared = 0;
  int mismatched = 0;

  jt51_timer_ctrl dut (
    .rst          (rst),
    .clk          (clk),
    .cen          (cen),
    .wr           (wr),
    .a0           (a0),
    .din          (din),
    .overflow_A   (overflow_A),
    .busy         (busy),
    .value_A      (value_A),
    .value_B      (value_B),
    .load_A       (load_A),
    .load_B       (load_B),
    .clr_flag_A   (clr_flag_A),
    .clr_flag_B   (clr_flag_B),
    .enable_irq_A (enable_irq_A),
    .enable_irq_B (enable_irq_B),
    .csm          (csm),
    .csm_kon      (csm_kon)
  );

  assign allOuts = {busy, value_A, value_B, load_A, load_B, clr_flag_A,
                    clr_flag_B, enable_irq_A, enable_irq_B, csm, csm_kon};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus cycle, called on a falling edge; returns on the next falling edge
  task automatic bus_write(input logic a0v, input logic [7:0] d);
    wr = 1'b1; a0 = a0v; din = d;
    @(negedge clk);
    wr = 1'b0; a0 = 1'b0; din = 8'h00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wait_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] d);
    wait_idle();
    bus_write(1'b0, addr);
    bus_write(1'b1, d);
  endtask

  task automatic pulse_overflow();
    overflow_A = 1'b1;
    @(negedge clk);
    overflow_A = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; wr = 1'b0; a0 = 1'b0; din = 8'h00; overflow_A = 1'b0;
    #2;
    compared++;
    if (allOuts !== 27'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_async: outputs got %h required 0", allOuts);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (allOuts !== 27'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_held: outputs got %h required 0", allOuts);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_values();
    write_reg(8'h10, 8'hA5);
    compared++;
    if (value_A !== 10'h294) begin
      mismatched++;
      $display("[TB] FAIL value_A_hi: got %h required 294", value_A);
    end
    write_reg(8'h11, 8'h02);
    compared++;
    if (value_A !== 10'h296) begin
      mismatched++;
      $display("[TB] FAIL value_A_full: got %h required 296", value_A);
    end
    write_reg(8'h12, 8'h3C);
    compared++;
    if (value_B !== 8'h3C) begin
      mismatched++;
      $display("[TB] FAIL value_B: got %h required 3C", value_B);
    end
  endtask

  task automatic test_busy();
    int busyCount;
    write_reg(8'h12, 8'h55);
    busyCount = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busyCount++;
      if (i == 10) begin
        wr = 1'b1; a0 = 1'b1; din = 8'hFF;
      end else begin
        wr = 1'b0; a0 = 1'b0; din = 8'h00;
      end
      @(negedge clk);
    end
    compared++;
    if (busyCount !== 64) begin
      mismatched++;
      $display("[TB] FAIL busy_len: got %0d clks required 64", busyCount);
    end
    compared++;
    if (value_B !== 8'h55) begin
      mismatched++;
      $display("[TB] FAIL busy_drop: value_B got %h required 55", value_B);
    end
    // Unknown address still opens the window; cen low freezes it
    write_reg(8'h13, 8'hEE);
    cen = 1'b0;
    repeat (80) @(negedge clk);
    compared++;
    if ({busy, value_A, value_B} !== {1'b1, 10'h296, 8'h55}) begin
      mismatched++;
      $display("[TB] FAIL busy_cen_hold: got %h required %h",
               {busy, value_A, value_B}, {1'b1, 10'h296, 8'h55});
    end
    cen = 1'b1;
  endtask

  task automatic test_ctrl();
    write_reg(8'h14, 8'h35);
    compared++;
    if ({clr_flag_B, clr_flag_A} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL clr_pulse: got %b required 11", {clr_flag_B, clr_flag_A});
    end
    compared++;
    if ({csm, enable_irq_B, enable_irq_A, load_B, load_A} !== 5'b00101) begin
      mismatched++;
      $display("[TB] FAIL ctrl_bits: got %b required 00101",
               {csm, enable_irq_B, enable_irq_A, load_B, load_A});
    end
    @(negedge clk);
    compared++;
    if ({clr_flag_B, clr_flag_A} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL clr_width: got %b required 00", {clr_flag_B, clr_flag_A});
    end
  endtask

  task automatic test_csm();
    int konCount, rises;
    logic prev;
    write_reg(8'h14, 8'h81);
    compared++;
    if ({csm, load_A, enable_irq_A} !== 3'b110) begin
      mismatched++;
      $display("[TB] FAIL csm_set: got %b required 110", {csm, load_A, enable_irq_A});
    end
    // Overflow without cen is not a trigger
    cen = 1'b0;
    pulse_overflow();
    cen = 1'b1;
    @(negedge clk);
    compared++;
    if (csm_kon !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL csm_no_cen: csm_kon got %b required 0", csm_kon);
    end
    pulse_overflow();
    konCount = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (csm_kon) konCount++;
      if (csm_kon && !prev) rises++;
      prev = csm_kon;
      @(negedge clk);
    end
    compared++;
    if (konCount !== 32 || rises !== 1) begin
      mismatched++;
      $display("[TB] FAIL csm_len: got %0d clks %0d pulses required 32 clks 1 pulse",
               konCount, rises);
    end
    pulse_overflow();
    konCount = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (csm_kon) konCount++;
      if (csm_kon && !prev) rises++;
      prev = csm_kon;
      overflow_A = (i == 19);
      @(negedge clk);
    end
    overflow_A = 1'b0;
    compared++;
    if (konCount !== 52 || rises !== 1) begin
      mismatched++;
      $display("[TB] FAIL csm_retrig: got %0d clks %0d pulses required 52 clks 1 pulse",
               konCount, rises);
    end
  endtask

  task automatic test_abort();
    logic seen;
    wait_idle();
    pulse_overflow();
    @(negedge clk);
    compared++;
    if (csm_kon !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL abort_pre: csm_kon got %b required 1", csm_kon);
    end
    bus_write(1'b1, 8'h01);
    compared++;
    if ({csm, csm_kon} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL abort_edge: csm,csm_kon got %b required 01", {csm, csm_kon});
    end
    @(negedge clk);
    compared++;
    if (csm_kon !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_drop: csm_kon got %b required 0", csm_kon);
    end
    pulse_overflow();
    seen = 1'b0;
    repeat (4) begin
      seen = seen | csm_kon;
      @(negedge clk);
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL csm_off_ignore: csm_kon got %b required 0", seen);
    end
    // Control write setting csm on the same edge as an overflow
    wait_idle();
    wr = 1'b1; a0 = 1'b1; din = 8'h81; overflow_A = 1'b1;
    @(negedge clk);
    wr = 1'b0; a0 = 1'b0; din = 8'h00; overflow_A = 1'b0;
    compared++;
    if ({csm, csm_kon} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL same_clk: csm,csm_kon got %b required 10", {csm, csm_kon});
    end
    @(negedge clk);
    compared++;
    if (csm_kon !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL same_clk_late: csm_kon got %b required 0", csm_kon);
    end
  endtask

  task automatic test_mid_reset();
    write_reg(8'h10, 8'hFF);
    compared++;
    if (value_A !== 10'h3FE) begin
      mismatched++;
      $display("[TB] FAIL value_A_ff: got %h required 3FE", value_A);
    end
    wait_idle();
    pulse_overflow();
    bus_write(1'b0, 8'h12);
    bus_write(1'b1, 8'h12);
    compared++;
    if ({busy, csm_kon, load_A} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL mid_pre: busy,csm_kon,load_A got %b required 111",
               {busy, csm_kon, load_A});
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({busy, csm_kon, load_A, value_A} !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: busy,csm_kon,load_A,value_A got %h required 0",
               {busy, csm_kon, load_A, value_A});
    end
    compared++;
    if (allOuts !== 27'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_all: outputs got %h required 0", allOuts);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Address latch is back at 0, so this write only opens the busy window
    bus_write(1'b1, 8'h99);
    compared++;
    if ({busy, value_B, value_A} !== {1'b1, 8'h00, 10'h000}) begin
      mismatched++;
      $display("[TB] FAIL post_reset_wr: busy,value_B,value_A got %h required %h",
               {busy, value_B, value_A}, {1'b1, 8'h00, 10'h000});
    end
    write_reg(8'h12, 8'h77);
    compared++;
    if (value_B !== 8'h77) begin
      mismatched++;
      $display("[TB] FAIL post_reset_B: got %h required 77", value_B);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_values();
    test_busy();
    test_ctrl();
    test_csm();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
